mux_rr: RTL and testbench



---
 rtl/mux_rr.sv | 99 +++++++++
 tb/tb_mux_rr.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr.sv
// N-channel valid/ready multiplexer with round-robin or fixed-select arbitration
// feeding a single registered output slot.
module mux_rr #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    output logic [SW-1:0]   out_sel,
    input  logic            out_ready
);

    logic [W-1:0]  out_data_q,  out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_sel_q,   out_sel_d;
    logic [SW-1:0] rr_ptr_q,    rr_ptr_d;

    logic          load_en;
    logic          grant_vld;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  ch_data [N];

    // Reset also blocks acceptance so no handshake completes on a reset edge.
    assign load_en = !rst && (!out_valid_q || out_ready);

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        assign ch_data[gi]  = in_data[gi*W +: W];
        assign in_ready[gi] = load_en && grant_vld && (grant_idx == SW'(gi));
    end

    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (mode) begin
            if ((int'(sel) < N) && in_valid[sel]) begin
                grant_vld = 1'b1;
                grant_idx = sel;
            end
        end else begin
            // Scan starts just past the last served channel and wraps.
            for (int i = 1; i <= N; i++) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!grant_vld && in_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = SW'(idx);
                end
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            if (grant_vld) begin
                out_valid_d = 1'b1;
                out_data_d  = ch_data[grant_idx];
                out_sel_d   = grant_idx;
                rr_ptr_d    = grant_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= SW'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_rr.sv
// Directed bench for mux_rr (N=4, W=8): reset, round-robin, sparse, backpressure,
// fixed select and drain, with hand-computed expectations.
module tb_mux_rr;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [1:0]  out_sel;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    mux_rr #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Settle combinational paths after changing inputs mid-cycle.
    task automatic settle();
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".sel"},   {30'd0, out_sel},   {30'd0, s});
        chk({tag, ".data"},  {24'd0, out_data},  {24'd0, d});
    endtask

    initial begin
        // Reset with every channel requesting
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = 2'd0;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst.ready", {28'd0, in_ready}, 32'h0);
            chk_out("rst", 1'b0, 2'd0, 8'h00);
        end

        // Round-robin with all valid: 0,1,2,3,0,1,2,3
        rst = 1'b0;
        settle();
        chk("rr.first_ready", {28'd0, in_ready}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out($sformatf("rr%0d", i), 1'b1, 2'(i % 4), 8'hA0 + 8'(i % 4));
            chk($sformatf("rr%0d.ready", i), {28'd0, in_ready}, 32'(1 << ((i + 1) % 4)));
        end

        // Sparse: ch1 and ch3 alternate, pointer currently at 3
        in_data  = {8'h33, 8'h00, 8'h11, 8'h00};
        in_valid = 4'b1010;
        settle();
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i % 2 == 0) chk_out($sformatf("sp%0d", i), 1'b1, 2'd1, 8'h11);
            else            chk_out($sformatf("sp%0d", i), 1'b1, 2'd3, 8'h33);
        end
        in_valid = 4'b0010;
        settle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("solo%0d", i), 1'b1, 2'd1, 8'h11);
        end

        // Backpressure: output holds ch1 word while new requests wait
        out_ready = 1'b0;
        in_data   = {8'h00, 8'hC2, 8'h00, 8'hC0};
        in_valid  = 4'b0101;
        settle();
        chk("bp.ready0", {28'd0, in_ready}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("bp%0d", i), 1'b1, 2'd1, 8'h11);
            chk($sformatf("bp%0d.ready", i), {28'd0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        settle();
        chk("bp.release_ready", {28'd0, in_ready}, 32'h4);
        tick();
        chk_out("bp.ch2", 1'b1, 2'd2, 8'hC2);
        in_valid = 4'b0001;
        settle();
        chk("bp.next_ready", {28'd0, in_ready}, 32'h1);
        tick();
        chk_out("bp.ch0", 1'b1, 2'd0, 8'hC0);
        in_valid = 4'b0000;
        tick();
        chk_out("bp.drain", 1'b0, 2'd0, 8'hC0);

        // Fixed select (legacy mux); ch2 requests but is not selected
        mode     = 1'b1;
        sel      = 2'd0;
        in_data  = {8'h00, 8'h55, 8'h0F, 8'hF0};
        in_valid = 4'b0111;
        settle();
        chk("fx.sel0_ready", {28'd0, in_ready}, 32'h1);
        tick();
        chk_out("fx.sel0", 1'b1, 2'd0, 8'hF0);
        sel = 2'd1;
        settle();
        chk("fx.sel1_ready", {28'd0, in_ready}, 32'h2);
        tick();
        chk_out("fx.sel1", 1'b1, 2'd1, 8'h0F);
        sel = 2'd3;
        settle();
        chk("fx.sel3_noreq", {28'd0, in_ready}, 32'h0);
        tick();
        chk_out("fx.sel3_drain", 1'b0, 2'd1, 8'h0F);

        // Back to round-robin: continues after ch1, so ch2 is next
        mode = 1'b0;
        settle();
        chk("fx.to_rr_ready", {28'd0, in_ready}, 32'h4);
        tick();
        chk_out("fx.to_rr", 1'b1, 2'd2, 8'h55);

        // Idle / drain: single ch2 word, then nothing
        in_valid = 4'b0000;
        settle();
        chk("idle.ready", {28'd0, in_ready}, 32'h0);
        tick();
        chk_out("idle0", 1'b0, 2'd2, 8'h55);
        tick();
        chk_out("idle1", 1'b0, 2'd2, 8'h55);

        // Reset mid-stream blocks acceptance and clears the slot
        in_valid = 4'b1111;
        in_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        tick();
        chk_out("pre_rst", 1'b1, 2'd3, 8'hD3);
        rst = 1'b1;
        settle();
        chk("mid_rst.ready", {28'd0, in_ready}, 32'h0);
        tick();
        chk_out("mid_rst", 1'b0, 2'd0, 8'h00);
        rst = 1'b0;
        settle();
        chk("post_rst.ready", {28'd0, in_ready}, 32'h1);
        tick();
        chk_out("post_rst", 1'b1, 2'd0, 8'hD0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
